// File: rtl/id_hazard_forward_unit_if.sv
// Forwarding-select encoding and the ID-stage <-> hazard/forward unit bundle.
// The ID stage drives the decoded operand fields; the unit returns selects and pipeline controls.
package id_hazard_forward_unit_pkg;
    typedef enum logic [1:0] {
        NO_FWD     = 2'd0,
        EX_ID_FWD  = 2'd1,
        MEM_ID_FWD = 2'd2,
        WB_ID_FWD  = 2'd3
    } ForwardingControl;
endpackage

interface id_hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import id_hazard_forward_unit_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_wr_en;
    logic                  id_is_load;
    logic                  branch_decision;

    ForwardingControl      fwd_reg_file_rd_sel_1;
    ForwardingControl      fwd_reg_file_rd_sel_2;
    logic                  stall_pc;
    logic                  stall_if_id;
    logic                  bubble_id_ex;
    logic                  flush_if_id;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_reg_wr_en, id_is_load, branch_decision,
        input  fwd_reg_file_rd_sel_1, fwd_reg_file_rd_sel_2,
               stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_reg_wr_en, id_is_load, branch_decision,
        output fwd_reg_file_rd_sel_1, fwd_reg_file_rd_sel_2,
               stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
               stall_count, flush_count
    );
endinterface

// File: rtl/id_hazard_forward_unit.sv
// ID-stage hazard and forwarding unit: shadows the EX/MEM/WB destinations, picks operand
// forward sources, inserts a one-cycle load-use stall and flushes IF/ID on a taken branch.
module id_hazard_forward_unit
    import id_hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                reset,
    id_hazard_forward_unit_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  load;
    } slot_t;

    slot_t            ex_slot;
    slot_t            mem_slot;
    slot_t            wb_slot;
    slot_t            ex_next;
    logic             load_hit;
    logic             stall;
    logic             flush;
    ForwardingControl sel_1;
    ForwardingControl sel_2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.wr && (s.rd == r) && (r != '0);
    endfunction

    // A load still in EX has no data yet, so it shadows any older writer of the same register.
    function automatic ForwardingControl pick_fwd(
        input logic                  valid,
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] rs,
        input slot_t                 ex,
        input slot_t                 mem,
        input slot_t                 wb
    );
        ForwardingControl sel;
        sel = NO_FWD;
        if (valid && uses) begin
            if (slot_writes(ex, rs))
                sel = ex.load ? NO_FWD : EX_ID_FWD;
            else if (slot_writes(mem, rs))
                sel = MEM_ID_FWD;
            else if (slot_writes(wb, rs))
                sel = WB_ID_FWD;
        end
        return sel;
    endfunction

    always_comb begin
        load_hit = ex_slot.valid && ex_slot.load && ex_slot.wr && (ex_slot.rd != '0) &&
                   ((bus.id_uses_rs1 && (bus.id_rs1 == ex_slot.rd)) ||
                    (bus.id_uses_rs2 && (bus.id_rs2 == ex_slot.rd)));
        stall = bus.id_valid && load_hit;
        flush = bus.id_valid && bus.branch_decision && !stall;

        sel_1 = pick_fwd(bus.id_valid, bus.id_uses_rs1, bus.id_rs1, ex_slot, mem_slot, wb_slot);
        sel_2 = pick_fwd(bus.id_valid, bus.id_uses_rs2, bus.id_rs2, ex_slot, mem_slot, wb_slot);

        ex_next = '0;
        if (bus.id_valid && !stall) begin
            ex_next.valid = 1'b1;
            ex_next.rd    = bus.id_rd;
            ex_next.wr    = bus.id_reg_wr_en;
            ex_next.load  = bus.id_is_load;
        end
    end

    // Shadow pipeline: a stalled or empty ID slot enters EX as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= ex_next;
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.fwd_reg_file_rd_sel_1 = sel_1;
    assign bus.fwd_reg_file_rd_sel_2 = sel_2;
    assign bus.stall_pc              = stall;
    assign bus.stall_if_id           = stall;
    assign bus.bubble_id_ex          = stall;
    assign bus.flush_if_id           = flush;
    assign bus.stall_count           = stall_cnt;
    assign bus.flush_count           = flush_cnt;

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Bench for id_hazard_forward_unit: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a list-of-in-flight-instructions model.
module tb_id_hazard_forward_unit;
    import id_hazard_forward_unit_pkg::*;

    localparam int AW    = 5;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    bit   check_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    id_hazard_forward_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    id_hazard_forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit load;
    } tb_instr_t;

    // Index 0 = youngest in-flight instruction (EX), 2 = oldest (WB).
    tb_instr_t in_flight[3];
    int        m_stalls;
    int        m_flushes;

    function automatic bit produces(tb_instr_t t, int r);
        return t.valid && t.wr && (t.rd == r) && (r != 0);
    endfunction

    function automatic int model_sel(bit uses, int rs);
        if (!bus.id_valid || !uses) return 0;
        for (int i = 0; i < 3; i++)
            if (produces(in_flight[i], rs))
                return (i == 0 && in_flight[0].load) ? 0 : i + 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        tb_instr_t ex;
        ex = in_flight[0];
        if (!bus.id_valid || !ex.load || !produces(ex, ex.rd)) return 1'b0;
        return (bus.id_uses_rs1 && int'(bus.id_rs1) == ex.rd) ||
               (bus.id_uses_rs2 && int'(bus.id_rs2) == ex.rd);
    endfunction

    function automatic bit model_flush();
        return bus.id_valid && bus.branch_decision && !model_stall();
    endfunction

    always @(posedge clk) begin
        bit st;
        bit fl;
        if (reset) begin
            for (int i = 0; i < 3; i++) in_flight[i] = '{0, 0, 0, 0};
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            st = model_stall();
            fl = model_flush();
            if (st) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
            if (fl) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
            in_flight[2] = in_flight[1];
            in_flight[1] = in_flight[0];
            if (st || !bus.id_valid)
                in_flight[0] = '{0, 0, 0, 0};
            else
                in_flight[0] = '{1, int'(bus.id_rd), bus.id_reg_wr_en, bus.id_is_load};
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            bit st;
            st = model_stall();
            check_output("sel_1",       int'(bus.fwd_reg_file_rd_sel_1), model_sel(bus.id_uses_rs1, int'(bus.id_rs1)));
            check_output("sel_2",       int'(bus.fwd_reg_file_rd_sel_2), model_sel(bus.id_uses_rs2, int'(bus.id_rs2)));
            check_output("stall_pc",    int'(bus.stall_pc),     int'(st));
            check_output("stall_if_id", int'(bus.stall_if_id),  int'(st));
            check_output("bubble",      int'(bus.bubble_id_ex), int'(st));
            check_output("flush",       int'(bus.flush_if_id),  int'(model_flush()));
            check_output("stall_count", int'(bus.stall_count),  m_stalls);
            check_output("flush_count", int'(bus.flush_count),  m_flushes);
        end
    end

    task automatic apply_stimulus(input bit valid, input int rs1, input int rs2,
                                  input bit u1, input bit u2, input int rd,
                                  input bit wr, input bit load, input bit br);
        bus.id_valid        = valid;
        bus.id_rs1          = AW'(rs1);
        bus.id_rs2          = AW'(rs2);
        bus.id_uses_rs1     = u1;
        bus.id_uses_rs2     = u2;
        bus.id_rd           = AW'(rd);
        bus.id_reg_wr_en    = wr;
        bus.id_is_load      = load;
        bus.branch_decision = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_output("rst sel_1", int'(bus.fwd_reg_file_rd_sel_1), int'(NO_FWD));
        check_output("rst stall", int'(bus.stall_pc), 0);
        check_output("rst flush", int'(bus.flush_if_id), 0);
        check_output("rst stall_count", int'(bus.stall_count), 0);

        // add x5 then sub reading x5/x6
        apply_stimulus(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
        apply_stimulus(1, 5, 6, 1, 1, 8, 1, 0, 0);
        @(negedge clk);
        check_output("alu sel_1", int'(bus.fwd_reg_file_rd_sel_1), int'(EX_ID_FWD));
        check_output("alu sel_2", int'(bus.fwd_reg_file_rd_sel_2), int'(NO_FWD));
        check_output("alu stall", int'(bus.stall_pc), 0);

        // lw x7 then consumer of x7 on rs2
        step();
        apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
        apply_stimulus(1, 1, 7, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("lu stall", int'(bus.stall_if_id), 1);
        check_output("lu bubble", int'(bus.bubble_id_ex), 1);
        check_output("lu stall sel_2", int'(bus.fwd_reg_file_rd_sel_2), int'(NO_FWD));
        step();
        @(negedge clk);
        check_output("lu stall gone", int'(bus.stall_pc), 0);
        check_output("lu stall_count", int'(bus.stall_count), 1);
        check_output("lu sel_2 mem", int'(bus.fwd_reg_file_rd_sel_2), int'(MEM_ID_FWD));

        // x3 written by three ALU ops in a row, then a non-writing reader sits in ID
        step();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0); step();
        end
        apply_stimulus(1, 3, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("x3 ex", int'(bus.fwd_reg_file_rd_sel_1), int'(EX_ID_FWD));
        step();
        @(negedge clk);
        check_output("x3 mem", int'(bus.fwd_reg_file_rd_sel_1), int'(MEM_ID_FWD));
        step();
        @(negedge clk);
        check_output("x3 wb", int'(bus.fwd_reg_file_rd_sel_1), int'(WB_ID_FWD));

        // x0 writers never forward or stall
        step();
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
        apply_stimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("x0 alu sel_1", int'(bus.fwd_reg_file_rd_sel_1), int'(NO_FWD));
        step();
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
        apply_stimulus(1, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("x0 load stall", int'(bus.stall_pc), 0);
        check_output("x0 load sel_2", int'(bus.fwd_reg_file_rd_sel_2), int'(NO_FWD));

        // taken beq waiting on lw x9
        step();
        apply_stimulus(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
        apply_stimulus(1, 9, 9, 1, 1, 0, 0, 0, 1);
        @(negedge clk);
        check_output("br stall", int'(bus.stall_pc), 1);
        check_output("br no flush", int'(bus.flush_if_id), 0);
        step();
        @(negedge clk);
        check_output("br flush", int'(bus.flush_if_id), 1);
        check_output("br stall_count", int'(bus.stall_count), 2);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("br flush_count", int'(bus.flush_count), 1);

        // reset while stalled
        step();
        apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
        apply_stimulus(1, 1, 7, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("rs stall before", int'(bus.stall_pc), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_output("rs stall after", int'(bus.stall_pc), 0);
        check_output("rs sel_2", int'(bus.fwd_reg_file_rd_sel_2), int'(NO_FWD));
        check_output("rs stall_count", int'(bus.stall_count), 0);
        check_output("rs flush_count", int'(bus.flush_count), 0);

        // drive both counters past their limit
        step();
        for (int i = 0; i < CMAX + 5; i++) begin
            apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
            apply_stimulus(1, 1, 7, 0, 1, 0, 0, 0, 0); step();
        end
        for (int i = 0; i < CMAX + 5; i++) begin
            apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("sat stall_count", int'(bus.stall_count), CMAX);
        check_output("sat flush_count", int'(bus.flush_count), CMAX);

        // random traffic over a small register set to provoke frequent matches
        step();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            apply_stimulus($urandom_range(0, 7) != 0,
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 3),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 3) == 0);
            step();
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_hazard_forward_unit.md
Name: id_hazard_forward_unit

Overview:
- Produces the forwarding-select and hazard controls consumed by the instruction-decode stage: `fwd_reg_file_rd_sel_1/2`, stall, bubble and flush.
- Keeps a shadow scoreboard of the destination registers of instructions in EX, MEM and WB.
- Compares the ID-stage source registers against that scoreboard.
- Stalls one cycle on a load-use hazard and flushes IF/ID when ID resolves a taken branch.
- Sits beside the ID stage in the core top level.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 16, width of the stall/flush performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction
id_rs1  in  REG_ADDR_W  instruction[19:15] in ID
id_rs2  in  REG_ADDR_W  instruction[24:20] in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_ADDR_W  instruction[11:7] in ID
id_reg_wr_en  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load; result is available only from MEM
branch_decision  in  1  branch taken, from the ID stage
fwd_reg_file_rd_sel_1  out  ForwardingControl  rs1 forward select
fwd_reg_file_rd_sel_2  out  ForwardingControl  rs2 forward select
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
bubble_id_ex  out  1  load NOP into ID/EX
flush_if_id  out  1  invalidate IF/ID on next edge
stall_count  out  CNT_W  saturating count of load-use stall cycles
flush_count  out  CNT_W  saturating count of branch flushes

Behaviour:
- Scoreboard: three registered slots, EX, MEM and WB. Each slot holds {valid, rd, wr, load}.
- Every edge, in order:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble when `stall` is high or `id_valid` is low.
  - Otherwise EX <= {1, id_rd, id_reg_wr_en, id_is_load}.
- The WB slot models the write to the register file on the same edge.
- A slot "writes r" when: valid & wr & rd == r & r != 0.
- Forward select for operand n (rs = id_rsn), combinational, youngest first:
  - EX writes rs and EX.load = 0 -> EX_ID_FWD.
  - else MEM writes rs -> MEM_ID_FWD. This covers both loads and ALU results.
  - else WB writes rs -> WB_ID_FWD. The register file has no write-through, so the read returns the old value that cycle.
  - else NO_FWD.
  - If id_usesn = 0 or id_valid = 0 -> NO_FWD.
- Load-use stall: stall = id_valid & EX.valid & EX.load & EX.wr & EX.rd != 0 & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)).
  - stall_pc = stall_if_id = bubble_id_ex = stall.
  - The stall lasts exactly one cycle: next cycle the load is in MEM and MEM_ID_FWD applies.
  - While stalled, the forward select for the EX-load match is don't-care, but must be driven as NO_FWD.
- Flush: flush_if_id = id_valid & branch_decision & ~stall.
  - A branch waiting on a load does not flush until its operands are valid.
  - A simultaneous stall and taken branch -> stall only.
- Counters:
  - stall_count increments on each cycle with stall = 1.
  - flush_count increments on each cycle with flush_if_id = 1.
  - Both saturate at 2^CNT_W - 1, with no wrap.
- Reset:
  - All slots invalid; both counters 0.
  - Resulting outputs: both selects NO_FWD; stall_pc, stall_if_id, bubble_id_ex and flush_if_id = 0. Outputs are combinational from the slots, so these hold in the cycle after reset.
  - Reset mid-stall clears the EX load slot, so stall is 0 the cycle after reset.
  - Reset has priority over slot shifting and counting.
- x0: never forwarded, never stalls, even when a slot has wr = 1 and rd = 0.
- Both operands matching different slots each get their own select. Both operands matching the EX load -> a single one-cycle stall.

Test Plan:
- Reset, then `add x5` in EX and ID `sub` reads rs1 = x5, rs2 = x6 (`uses_rs1` = `uses_rs2` = 1) -> sel_1 = EX_ID_FWD, sel_2 = NO_FWD, no stall.
- `lw x7` in EX, ID reads rs2 = x7 -> stall = 1 for exactly one cycle, stall_count = 1, EX slot bubbled. Next cycle sel_2 = MEM_ID_FWD.
- x3 written by WB, MEM and EX (ALU) simultaneously, ID reads rs1 = x3 -> EX_ID_FWD. Repeat with EX bubbled -> MEM_ID_FWD; with only WB -> WB_ID_FWD.
- Writer of x0 in EX (ALU) and in EX (load), ID reads x0 -> NO_FWD, stall = 0.
- `beq` in ID reading x9 while `lw x9` is in EX, branch_decision = 1 -> cycle 1: stall = 1, flush = 0; cycle 2: flush_if_id = 1, flush_count = 1.
- Assert reset during a load-use stall -> next cycle stall = 0, selects NO_FWD, counters 0. Force the counters to the limit with 2^CNT_W stalls -> they hold at all-ones.
